// File: rtl/innings_sequencer_pkg.sv
// rtl/innings_sequencer_pkg.sv - shared state, outcome and winner codes plus the ball decoder
package innings_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INN1  = 3'd1,
    ST_BREAK = 3'd2,
    ST_INN2  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] OUT_WKT_A  = 4'd12;
  localparam logic [3:0] OUT_WIDE   = 4'd13;
  localparam logic [3:0] OUT_NOBALL = 4'd14;
  localparam logic [3:0] OUT_WKT_B  = 4'd15;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_TEAM1 = 2'b01;
  localparam logic [1:0] WIN_TEAM2 = 2'b10;
  localparam logic [1:0] WIN_TIE   = 2'b11;

  typedef struct packed {
    logic [2:0] runs;
    logic       wicket;
    logic       legal;
  } ball_t;

  function automatic ball_t decode_ball(input logic [3:0] code);
    ball_t b;
    b.runs   = 3'd0;
    b.wicket = 1'b0;
    b.legal  = 1'b1;
    case (code)
      4'd3, 4'd4, 4'd5:       b.runs = 3'd1;
      4'd6, 4'd7:             b.runs = 3'd2;
      4'd8:                   b.runs = 3'd3;
      4'd9, 4'd10:            b.runs = 3'd4;
      4'd11:                  b.runs = 3'd6;
      OUT_WKT_A, OUT_WKT_B:   b.wicket = 1'b1;
      // Extras score one run but do not count as a ball of the over
      OUT_WIDE, OUT_NOBALL: begin
        b.runs  = 3'd1;
        b.legal = 1'b0;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/innings_sequencer_bowl_sync_edge.sv
// rtl/innings_sequencer_bowl_sync_edge.sv - bowl button synchronizer with one-cycle rising-edge press
module innings_sequencer_bowl_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_fpga,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/innings_sequencer.sv
// rtl/innings_sequencer.sv - master game FSM: press to delivery strobe, scoring and innings sequencing
module innings_sequencer
  import innings_sequencer_pkg::*;
#(
  parameter int MAX_OVERS      = 2,
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_WKTS       = 10,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       bowl_btn,
  input  logic [3:0] lfsr_out,
  output logic       delivery,
  output logic [3:0] outcome,
  output logic       teamSwitch,
  output logic       inningOver,
  output logic       gameOver,
  output logic [7:0] runs1,
  output logic [7:0] runs2,
  output logic [3:0] wkts,
  output logic [6:0] legal_balls,
  output logic [1:0] winner
);

  localparam int MAX_BALLS = MAX_OVERS * BALLS_PER_OVER;

  logic       press;
  state_t     state_q, state_d;
  ball_t      ball;
  logic       inn_active;
  logic       inn_end;
  logic [7:0] runs_bat;
  logic [8:0] run_sum;
  logic [7:0] runs_bat_next;

  innings_sequencer_bowl_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bowl_sync_edge (
    .clk_fpga(clk_fpga),
    .reset   (reset),
    .btn     (bowl_btn),
    .press   (press)
  );

  always_comb ball = decode_ball(lfsr_out);

  assign inn_active    = (state_q == ST_INN1) || (state_q == ST_INN2);
  assign runs_bat      = (state_q == ST_INN2) ? runs2 : runs1;
  assign run_sum       = {1'b0, runs_bat} + {6'd0, ball.runs};
  assign runs_bat_next = run_sum[8] ? 8'hFF : run_sum[7:0];
  // Counters only move on delivery edges, so this sees the updated values one cycle later
  assign inn_end       = (legal_balls == 7'(MAX_BALLS)) || (wkts == 4'(MAX_WKTS));

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    teamSwitch = 1'b0;
    inningOver = 1'b0;
    gameOver   = 1'b0;
    case (state_q)
      ST_IDLE:  if (press) state_d = ST_INN1;
      ST_INN1:  if (inn_end) state_d = ST_BREAK;
      ST_BREAK: begin
        inningOver = 1'b1;
        if (press) state_d = ST_INN2;
      end
      ST_INN2: begin
        teamSwitch = 1'b1;
        if (inn_end || (runs2 > runs1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        teamSwitch = 1'b1;
        inningOver = 1'b1;
        gameOver   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      delivery    <= 1'b0;
      outcome     <= 4'd0;
      runs1       <= 8'd0;
      runs2       <= 8'd0;
      wkts        <= 4'd0;
      legal_balls <= 7'd0;
      winner      <= WIN_NONE;
    end else begin
      delivery <= 1'b0;
      if ((state_q == ST_IDLE) && press) begin
        runs1       <= 8'd0;
        runs2       <= 8'd0;
        wkts        <= 4'd0;
        legal_balls <= 7'd0;
        winner      <= WIN_NONE;
      end
      if ((state_q == ST_BREAK) && press) begin
        wkts        <= 4'd0;
        legal_balls <= 7'd0;
      end
      if (inn_active && press) begin
        delivery <= 1'b1;
        outcome  <= lfsr_out;
        if (state_q == ST_INN2) runs2 <= runs_bat_next;
        else                    runs1 <= runs_bat_next;
        if (ball.wicket && (wkts != 4'(MAX_WKTS)))
          wkts <= wkts + 4'd1;
        if (ball.legal && (legal_balls != 7'(MAX_BALLS)))
          legal_balls <= legal_balls + 7'd1;
      end
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
        if (runs1 > runs2)      winner <= WIN_TEAM1;
        else if (runs2 > runs1) winner <= WIN_TEAM2;
        else                    winner <= WIN_TIE;
      end
    end
  end

endmodule

// File: tb/tb_innings_sequencer.sv
// tb/tb_innings_sequencer.sv - scoreboard bench for innings_sequencer against a game-level model
module tb_innings_sequencer;

  logic       clk_fpga = 1'b0;
  logic       reset    = 1'b1;
  logic       bowl_btn = 1'b0;
  logic [3:0] lfsr_out = 4'd0;
  logic       delivery;
  logic [3:0] outcome;
  logic       teamSwitch, inningOver, gameOver;
  logic [7:0] runs1, runs2;
  logic [3:0] wkts;
  logic [6:0] legal_balls;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  innings_sequencer dut (
    .clk_fpga   (clk_fpga),
    .reset      (reset),
    .bowl_btn   (bowl_btn),
    .lfsr_out   (lfsr_out),
    .delivery   (delivery),
    .outcome    (outcome),
    .teamSwitch (teamSwitch),
    .inningOver (inningOver),
    .gameOver   (gameOver),
    .runs1      (runs1),
    .runs2      (runs2),
    .wkts       (wkts),
    .legal_balls(legal_balls),
    .winner     (winner)
  );

  always #5 clk_fpga = ~clk_fpga;

  typedef struct {
    int code;
    int r1;
    int r2;
    int w;
    int b;
    int ts;
    int io_after;
    int go_after;
    int ts_after;
    int win;
  } exp_t;

  exp_t sb[$];

  // phase: 0 idle, 1 first innings, 2 break, 3 second innings, 4 done
  int m_phase, m_r1, m_r2, m_w, m_b, m_win, m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_r1 = 0; m_r2 = 0; m_w = 0; m_b = 0; m_win = 0; m_out = 0;
  endfunction

  function automatic void model_press(input int code);
    int add, wk, lg, ended;
    exp_t e;
    case (m_phase)
      0: begin m_phase = 1; m_r1 = 0; m_r2 = 0; m_w = 0; m_b = 0; m_win = 0; end
      2: begin m_phase = 3; m_w = 0; m_b = 0; end
      1, 3: begin
        add = 0; wk = 0; lg = 1;
        if (code <= 2)                  add = 0;
        else if (code <= 5)             add = 1;
        else if (code <= 7)             add = 2;
        else if (code == 8)             add = 3;
        else if (code <= 10)            add = 4;
        else if (code == 11)            add = 6;
        else if (code == 12 || code == 15) wk = 1;
        else begin add = 1; lg = 0; end
        if (m_phase == 1) m_r1 = (m_r1 + add > 255) ? 255 : m_r1 + add;
        else              m_r2 = (m_r2 + add > 255) ? 255 : m_r2 + add;
        m_w += wk;
        m_b += lg;
        m_out = code;
        ended = (m_b == 12 || m_w == 10 || (m_phase == 3 && m_r2 > m_r1)) ? 1 : 0;
        e.code = code; e.r1 = m_r1; e.r2 = m_r2; e.w = m_w; e.b = m_b;
        e.ts = (m_phase == 3) ? 1 : 0;
        if (ended != 0) begin
          if (m_phase == 1) m_phase = 2;
          else begin
            m_phase = 4;
            m_win = (m_r1 > m_r2) ? 1 : (m_r2 > m_r1) ? 2 : 3;
          end
        end
        e.io_after = (m_phase == 2 || m_phase == 4) ? 1 : 0;
        e.go_after = (m_phase == 4) ? 1 : 0;
        e.ts_after = (m_phase == 3 || m_phase == 4) ? 1 : 0;
        e.win = m_win;
        sb.push_back(e);
      end
      default: ;
    endcase
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_runs1"}, runs1, m_r1);
    chk({tag, "_runs2"}, runs2, m_r2);
    chk({tag, "_wkts"}, wkts, m_w);
    chk({tag, "_legal"}, legal_balls, m_b);
    chk({tag, "_outcome"}, outcome, m_out);
    chk({tag, "_teamSwitch"}, teamSwitch, (m_phase == 3 || m_phase == 4) ? 1 : 0);
    chk({tag, "_inningOver"}, inningOver, (m_phase == 2 || m_phase == 4) ? 1 : 0);
    chk({tag, "_gameOver"}, gameOver, (m_phase == 4) ? 1 : 0);
    chk({tag, "_winner"}, winner, m_win);
    chk({tag, "_delivery"}, delivery, 0);
  endtask

  task automatic press(input int code);
    model_press(code);
    lfsr_out = 4'(code);
    @(posedge clk_fpga); #1 bowl_btn = 1'b1;
    repeat (4) @(posedge clk_fpga);
    #1 bowl_btn = 1'b0;
    repeat (4) @(posedge clk_fpga);
    #1 lfsr_out = 4'($urandom_range(0, 15));
    chk("missing_delivery", sb.size(), 0);
    sb.delete();
    check_state("post_press");
  endtask

  task automatic do_reset();
    @(posedge clk_fpga); #2 reset = 1'b1;
    bowl_btn = 1'b0;
    model_reset();
    sb.delete();
    repeat (3) @(posedge clk_fpga);
    @(negedge clk_fpga) reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_fpga);
      if (!reset && delivery === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got 1 expected 0 (outcome %0d)", outcome);
        end else begin
          e = sb.pop_front();
          chk("del_outcome", outcome, e.code);
          chk("del_runs1", runs1, e.r1);
          chk("del_runs2", runs2, e.r2);
          chk("del_wkts", wkts, e.w);
          chk("del_legal", legal_balls, e.b);
          chk("del_teamSwitch", teamSwitch, e.ts);
          chk("del_inningOver", inningOver, 0);
          chk("del_gameOver", gameOver, 0);
          @(negedge clk_fpga);
          chk("after_delivery_pulse", delivery, 0);
          chk("after_inningOver", inningOver, e.io_after);
          chk("after_gameOver", gameOver, e.go_after);
          chk("after_teamSwitch", teamSwitch, e.ts_after);
          if (e.go_after != 0) chk("after_winner", winner, e.win);
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    model_reset();
    repeat (3) @(posedge clk_fpga);
    #1 check_state("reset");
    @(negedge clk_fpga) reset = 1'b0;

    // Full first innings of fours
    press(0);
    repeat (12) press(9);
    chk("t1_runs1", runs1, 48);
    chk("t1_inningOver", inningOver, 1);

    // Extras, ten wickets, chase of 10 won on the second six
    do_reset();
    press(0);
    repeat (3) press(13);
    chk("t2_runs1", runs1, 3);
    chk("t2_legal", legal_balls, 0);
    chk("t2_inningOver", inningOver, 0);
    repeat (7) press(14);
    repeat (10) press(12);
    chk("t4_break", inningOver, 1);
    press($urandom_range(0, 15));
    chk("t4_teamSwitch", teamSwitch, 1);
    chk("t4_wkts", wkts, 0);
    chk("t4_runs1_held", runs1, 10);
    repeat (4) press(11);
    chk("t3_runs2", runs2, 12);
    chk("t3_winner", winner, 2);
    chk("t3_gameOver", gameOver, 1);

    // Saturation and tie
    do_reset();
    press(0);
    repeat (255) press($urandom_range(13, 14));
    chk("t5_sat1", runs1, 255);
    repeat (3) press(11);
    chk("t5_sat1_hold", runs1, 255);
    repeat (9) press($urandom_range(0, 2));
    press(0);
    repeat (255) press($urandom_range(13, 14));
    repeat (12) press(11);
    chk("t5_sat2", runs2, 255);
    chk("t5_tie", winner, 3);

    // Random first innings, async reset mid second innings, then a random game
    do_reset();
    press(0);
    n = 0;
    while (m_phase == 1 && n < 200) begin press($urandom_range(0, 15)); n++; end
    press($urandom_range(0, 15));
    repeat (2) press($urandom_range(0, 2));
    @(posedge clk_fpga); #2 reset = 1'b1;
    model_reset();
    #1 check_state("async_reset");
    @(negedge clk_fpga) reset = 1'b0;
    press($urandom_range(0, 15));
    chk("t6_reenter_teamSwitch", teamSwitch, 0);
    n = 0;
    while (m_phase != 4 && n < 400) begin press($urandom_range(0, 15)); n++; end
    chk("random_game_done", gameOver, 1);
    repeat (2) press($urandom_range(0, 15));

    repeat (4) @(posedge clk_fpga);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
